apb_requester: RTL

// - APB4 requester (bridge) FSM: takes single transfers on a valid/ready command port and drives the APB bus.
// - Consumes the shared apb_pkg: IDLE/SETUP/ACCESS state enum, bus widths, validAlign().
// - Sits directly upstream of the APB completer(s).
// - Returns one response per accepted command, including misalignment and timeout errors.

---
 rtl/apb_pkg.sv | 30 +++
 rtl/apb_wait_timer.sv | 39 +++
 rtl/apb_requester.sv | 131 +++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, requester state encoding, command record
// and the address alignment helper.
package apb_pkg;

    localparam int unsigned ADDR_WIDTH      = 32;
    localparam int unsigned DATA_WIDTH      = 32;
    localparam int unsigned STRB_WIDTH      = DATA_WIDTH / 8;
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] strb;
    } apb_cmd_t;

    // An address is legal when it is aligned to the full data bus width.
    function automatic logic validAlign(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] mask;
        mask = ADDR_WIDTH'(STRB_WIDTH - 1);
        return (addr & mask) == '0;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating counter of ACCESS cycles spent waiting for PREADY; flags the cycle
// in which the wait limit is reached.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] MaxCnt  = CntW'(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] LastCnt = (TIMEOUT_CYCLES > 0) ? CntW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CntW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the wait cycle that brings the count up to the limit.
    assign expired = (TIMEOUT_CYCLES != 0) && enable && (cnt_q >= LastCnt);

endmodule

// File: rtl/apb_requester.sv
// APB4 requester: accepts single transfers on a valid/ready command port, runs
// them on the APB bus and returns exactly one response per accepted command.
module apb_requester #(
    parameter int unsigned ADDR_WIDTH     = apb_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = apb_pkg::DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = apb_pkg::TIMEOUT_DEFAULT,
    parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [STRB_WIDTH-1:0] PSTRB,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PSLVERR
);

    import apb_pkg::*;

    apb_state_e            state_d, state_q;
    apb_cmd_t              cmd_d, cmd_q;
    logic                  pend_d, pend_q;
    logic                  rsp_valid_d, rsp_valid_q;
    logic                  rsp_err_d, rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_d, rsp_rdata_q;
    logic                  accept, aligned, start, expired, done;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .clear  (state_q == StSetup),
        .enable ((state_q == StAccess) && !PREADY),
        .expired(expired)
    );

    // A misaligned command taken while a transfer completes owes its error
    // response one cycle later; hold off new commands until it has gone out.
    assign cmd_ready = PRESETn && (((state_q == StIdle) && !pend_q) ||
                                   ((state_q == StAccess) && PREADY));
    assign accept    = cmd_valid && cmd_ready;
    assign aligned   = validAlign(cmd_addr);
    assign start     = accept && aligned;
    assign done      = (state_q == StAccess) && PREADY;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        pend_d      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;

        case (state_q)
            StIdle:   if (start) state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: begin
                if (PREADY) begin
                    state_d = start ? StSetup : StIdle;
                end else if (expired) begin
                    state_d = StIdle;
                end
            end
            default:  state_d = StIdle;
        endcase

        if (start) begin
            cmd_d.write = cmd_write;
            cmd_d.addr  = cmd_addr;
            cmd_d.strb  = cmd_write ? cmd_strb : '0;
            if (cmd_write) begin
                cmd_d.wdata = cmd_wdata;
            end
        end

        if (done) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = PSLVERR;
            if (!cmd_q.write) begin
                rsp_rdata_d = PRDATA;
            end
            pend_d = accept && !aligned;
        end else if (pend_q || (accept && !aligned) || expired) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            pend_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            pend_q      <= pend_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign PSEL      = (state_q != StIdle);
    assign PENABLE   = (state_q == StAccess);
    assign PADDR     = cmd_q.addr;
    assign PWRITE    = cmd_q.write;
    assign PWDATA    = cmd_q.wdata;
    assign PSTRB     = cmd_q.strb;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
